// File: rtl/ui_pkg.sv
// Shared types for the dual-axis measurement sequencer.
package ui_pkg;

    localparam int unsigned UI_NUM_AXES = 2;

    typedef logic [$clog2(UI_NUM_AXES)-1:0] ui_axis_t;

    typedef enum logic [3:0] {
        StIdle,
        StSettle,
        StConvert,
        StCap0,
        StCap1,
        StReport,
        StClrSet,
        StClrPulse,
        StClrHold
    } ui_sched_state_t;

    // One-hot mask with only the given axis set.
    function automatic logic [UI_NUM_AXES-1:0] ui_axis_onehot(input ui_axis_t axis);
        logic [UI_NUM_AXES-1:0] oh;
        oh       = '0;
        oh[axis] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ui_rr_pick.sv
// Round-robin choice of the next axis to convert: prefer the axis after the
// last-served one, fall back to the last-served axis if it is the only one enabled.
module ui_rr_pick
    import ui_pkg::*;
(
    input  logic [UI_NUM_AXES-1:0] axis_en,
    input  ui_axis_t               last_axis,
    output logic                   pick_valid,
    output ui_axis_t               pick_axis
);

    ui_axis_t other_axis;

    assign other_axis = ~last_axis;
    assign pick_valid = |axis_en;
    assign pick_axis  = axis_en[other_axis] ? other_axis : last_axis;

endmodule

// File: rtl/ui_axis_scheduler.sv
// Shares one conversion engine between two axes and sequences the two-channel
// latch (select / enable / async clear). Clears are deferred until no conversion
// is in flight and the select is always settled before ACLEAR or ENABLE fire.
// Optional CONV_DONE watchdog: define UI_AXIS_SCHED_TIMEOUT_EN.
module ui_axis_scheduler
    import ui_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                   CLOCK,
    input  logic                   ACLEAR_N,
    input  logic                   RUN,
    input  logic [UI_NUM_AXES-1:0] AXIS_EN,
    input  logic [UI_NUM_AXES-1:0] CLR_REQ,
    input  logic                   CONV_DONE,
    output logic                   CONV_START,
    output logic                   LATCH_AXIS_SEL,
    output logic                   LATCH_ENABLE,
    output logic                   LATCH_ACLEAR,
    output logic [UI_NUM_AXES-1:0] SAMPLE_VALID,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR
);

    localparam logic [CNT_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    ui_sched_state_t        state_q, state_d;
    ui_axis_t               axis_q, axis_d;
    ui_axis_t               last_q, last_d, last_eff;
    logic [CNT_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [UI_NUM_AXES-1:0] pend_q, pend_d, pend_eff, clr_done;
    logic                   done_q;
    logic                   decide;
    logic                   pick_valid;
    ui_axis_t               pick_axis;
    logic                   tmo_fire;

    logic                   conv_start_q, conv_start_d;
    logic                   enable_q, enable_d;
    logic                   aclear_q, aclear_d;
    logic [UI_NUM_AXES-1:0] sv_q, sv_d;
    logic                   busy_q, busy_d;

    // In REPORT the axis just served already counts as last-served for the decision.
    assign last_eff = (state_q == StReport) ? axis_q : last_q;

    ui_rr_pick u_rr_pick (
        .axis_en    (AXIS_EN),
        .last_axis  (last_eff),
        .pick_valid (pick_valid),
        .pick_axis  (pick_axis)
    );

    // Next-state, target axis, settle counter and pending-clear bookkeeping.
    always_comb begin
        state_d      = state_q;
        axis_d       = axis_q;
        last_d       = last_eff;
        settle_cnt_d = settle_cnt_q;
        clr_done     = '0;
        decide       = 1'b0;
        unique case (state_q)
            StIdle:     decide = 1'b1;
            StSettle: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = StConvert;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            StConvert: begin
                // A result beats a simultaneous watchdog expiry.
                if (done_q) begin
                    state_d = StCap0;
                end else if (tmo_fire) begin
                    state_d = StReport;
                end
            end
            StCap0:     state_d = StCap1;
            StCap1:     state_d = StReport;
            StReport:   decide = 1'b1;
            StClrSet:   state_d = StClrPulse;
            StClrPulse: state_d = StClrHold;
            StClrHold: begin
                clr_done = ui_axis_onehot(axis_q);
                decide   = 1'b1;
            end
            default:    state_d = StIdle;
        endcase

        pend_eff = pend_q & ~clr_done;

        if (decide) begin
            if (|pend_eff) begin
                state_d = StClrSet;
                axis_d  = pend_eff[0] ? ui_axis_t'(0) : ui_axis_t'(1);
            end else if (RUN && pick_valid) begin
                state_d      = (SETTLE_CYCLES == 0) ? StConvert : StSettle;
                axis_d       = pick_axis;
                settle_cnt_d = '0;
            end else begin
                state_d = StIdle;
            end
        end

        // A request in the same cycle its bit is retired re-arms it.
        pend_d = pend_eff | CLR_REQ;
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        conv_start_d = (state_d == StConvert) && (state_q != StConvert);
        enable_d     = (state_d == StCap0) || (state_d == StCap1);
        aclear_d     = (state_d == StClrPulse);
        sv_d         = (state_q == StCap1) ? ui_axis_onehot(axis_q) : '0;
        busy_d       = (state_d != StIdle);
    end

    // State, sequencing registers and registered outputs.
    always_ff @(posedge CLOCK or negedge ACLEAR_N) begin
        if (!ACLEAR_N) begin
            state_q      <= StIdle;
            axis_q       <= '0;
            last_q       <= ui_axis_t'(1);
            settle_cnt_q <= '0;
            pend_q       <= '0;
            done_q       <= 1'b0;
            conv_start_q <= 1'b0;
            enable_q     <= 1'b0;
            aclear_q     <= 1'b0;
            sv_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            axis_q       <= axis_d;
            last_q       <= last_d;
            settle_cnt_q <= settle_cnt_d;
            pend_q       <= pend_d;
            // Only a CONV_DONE seen in CONVERT after the start cycle is a result.
            done_q       <= CONV_DONE && (state_q == StConvert) && !conv_start_q;
            conv_start_q <= conv_start_d;
            enable_q     <= enable_d;
            aclear_q     <= aclear_d;
            sv_q         <= sv_d;
            busy_q       <= busy_d;
        end
    end

`ifdef UI_AXIS_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_err_q;

    assign tmo_fire = (state_q == StConvert) && (tmo_cnt_q == TMO_LAST) && !done_q;

    // Watchdog: counts cycles spent in CONVERT; error flag is sticky until reset.
    always_ff @(posedge CLOCK or negedge ACLEAR_N) begin
        if (!ACLEAR_N) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StConvert) ? tmo_cnt_q + 1'b1 : '0;
            if (tmo_fire) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign TIMEOUT_ERR = tmo_err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
    assign tmo_fire       = 1'b0;
    assign TIMEOUT_ERR    = 1'b0;
`endif

    assign CONV_START     = conv_start_q;
    assign LATCH_AXIS_SEL = axis_q;
    assign LATCH_ENABLE   = enable_q;
    assign LATCH_ACLEAR   = aclear_q;
    assign SAMPLE_VALID   = sv_q;
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_ui_axis_scheduler.sv
// Scoreboard bench for ui_axis_scheduler: stimulus pushes expected SAMPLE_VALID
// and LATCH_ACLEAR events; a monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_ui_axis_scheduler;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 16;

    logic       clk = 1'b0;
    logic       aclear_n;
    logic       run;
    logic [1:0] axis_en;
    logic [1:0] clr_req;
    logic       conv_done;
    logic       conv_start;
    logic       sel;
    logic       latch_enable;
    logic       latch_aclear;
    logic [1:0] sample_valid;
    logic       busy;
    logic       timeout_err;

    ui_axis_scheduler #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .CLOCK          (clk),
        .ACLEAR_N       (aclear_n),
        .RUN            (run),
        .AXIS_EN        (axis_en),
        .CLR_REQ        (clr_req),
        .CONV_DONE      (conv_done),
        .CONV_START     (conv_start),
        .LATCH_AXIS_SEL (sel),
        .LATCH_ENABLE   (latch_enable),
        .LATCH_ACLEAR   (latch_aclear),
        .SAMPLE_VALID   (sample_valid),
        .BUSY           (busy),
        .TIMEOUT_ERR    (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] sv; int at; } sv_exp_t;
    typedef struct { logic axis; int at; } clr_exp_t;

    sv_exp_t  sv_q[$];
    clr_exp_t clr_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    int eng_delay    = 3;
    bit eng_mute     = 1'b0;
    bit eng_spurious = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_sv(input logic [1:0] v, input int at);
        sv_q.push_back('{sv: v, at: at});
    endtask

    task automatic push_clr(input logic a, input int at);
        clr_q.push_back('{axis: a, at: at});
    endtask

    // Returns at the falling edge inside cycle n.
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Engine model: CONV_DONE pulses eng_delay cycles after CONV_START.
    initial begin : engine
        int cnt;
        cnt       = 0;
        conv_done = 1'b0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !eng_mute) conv_done = 1'b1;
            end
            if (conv_start) begin
                cnt = eng_delay;
                if (eng_spurious) conv_done = 1'b1;
            end
        end
    end

    // Monitor: pops expected events and checks select stability around latch strobes.
    initial begin : monitor
        logic     prev_sel;
        logic     acl_after;
        logic     acl_sel;
        logic     en_sel;
        int       en_run;
        sv_exp_t  se;
        clr_exp_t ce;
        prev_sel  = 1'b0;
        acl_after = 1'b0;
        acl_sel   = 1'b0;
        en_sel    = 1'b0;
        en_run    = 0;
        forever begin
            @(negedge clk);
            if (!aclear_n) begin
                en_run    = 0;
                acl_after = 1'b0;
                prev_sel  = 1'b0;
            end else begin
                if (acl_after) begin
                    check("aclear_sel_after", sel, acl_sel);
                    acl_after = 1'b0;
                end
                if (latch_aclear) begin
                    if (clr_q.size() == 0) begin
                        check("aclear_unexpected", latch_aclear, 0);
                    end else begin
                        ce = clr_q.pop_front();
                        check("aclear_axis", sel, ce.axis);
                        check("aclear_cycle", cyc, ce.at);
                        check("aclear_sel_before", sel, prev_sel);
                    end
                    acl_after = 1'b1;
                    acl_sel   = sel;
                end
                if (latch_enable) begin
                    if (en_run == 0) en_sel = sel;
                    else check("enable_sel_stable", sel, en_sel);
                    en_run++;
                end else if (en_run != 0) begin
                    check("enable_len", en_run, 2);
                    en_run = 0;
                end
                if (sample_valid != 2'b00) begin
                    if (sv_q.size() == 0) begin
                        check("sv_unexpected", sample_valid, 0);
                    end else begin
                        se = sv_q.pop_front();
                        check("sv_value", sample_valid, se.sv);
                        check("sv_cycle", cyc, se.at);
                        check("sv_sel", sel, se.sv[1]);
                    end
                end
                prev_sel = sel;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int n;
        int k;
        aclear_n = 1'b0;
        run      = 1'b0;
        axis_en  = 2'b00;
        clr_req  = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_outputs", {conv_start, sel, latch_enable, latch_aclear,
                              sample_valid, busy, timeout_err}, 0);
        #2 aclear_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_sel", sel, 0);

        // Both axes, D=3, spurious DONE in every start cycle; RUN dropped mid-conversion.
        n = cyc;
        axis_en      = 2'b11;
        eng_delay    = 3;
        eng_spurious = 1'b1;
        run          = 1'b1;
        push_sv(2'b01, n + 12);
        push_sv(2'b10, n + 24);
        push_sv(2'b01, n + 36);
        wait_cyc(n + 5);
        check("b_conv_start", conv_start, 1);
        wait_cyc(n + 30);
        run = 1'b0;
        wait_cyc(n + 36);
        check("b_busy_report", busy, 1);
        wait_cyc(n + 37);
        check("b_busy_idle", busy, 0);
        eng_spurious = 1'b0;

        // Axis 1 only; clear of axis 0 requested during the third conversion.
        wait_cyc(n + 40);
        n = cyc;
        axis_en = 2'b10;
        run     = 1'b1;
        push_sv(2'b10, n + 12);
        push_sv(2'b10, n + 24);
        push_sv(2'b10, n + 36);
        push_clr(1'b0, n + 38);
        wait_cyc(n + 20);
        check("c_sel_held", sel, 1);
        wait_cyc(n + 30);
        clr_req = 2'b01;
        wait_cyc(n + 31);
        clr_req = 2'b00;
        run     = 1'b0;
        wait_cyc(n + 37);
        check("c_clrset_sel", sel, 0);
        check("c_clrset_busy", busy, 1);
        wait_cyc(n + 40);
        check("c_busy_idle", busy, 0);

        // Both clears requested at once while idle: axis 0 then axis 1.
        wait_cyc(n + 42);
        n = cyc;
        clr_req = 2'b11;
        push_clr(1'b0, n + 3);
        push_clr(1'b1, n + 6);
        wait_cyc(n + 1);
        clr_req = 2'b00;
        wait_cyc(n + 7);
        check("e_busy_hold", busy, 1);
        wait_cyc(n + 8);
        check("e_busy_idle", busy, 0);
        wait_cyc(n + 10);

`ifdef UI_AXIS_SCHED_TIMEOUT_EN
        // Engine silent on axis 0: watchdog fires, axis 1 is served next.
        n = cyc;
        axis_en  = 2'b11;
        eng_mute = 1'b1;
        run      = 1'b1;
        push_sv(2'b10, n + 33);
        wait_cyc(n + 20);
        check("f_err_before", timeout_err, 0);
        wait_cyc(n + 21);
        check("f_err_set", timeout_err, 1);
        eng_mute = 1'b0;
        wait_cyc(n + 27);
        run = 1'b0;
        wait_cyc(n + 34);
        check("f_busy_idle", busy, 0);
        check("f_err_sticky", timeout_err, 1);
        wait_cyc(n + 38);
`else
        check("tmo_err_tied", timeout_err, 0);
`endif

        // D=1; reset asserted while the third conversion is in CAP0.
        n = cyc;
        eng_delay = 1;
        axis_en   = 2'b11;
        run       = 1'b1;
        push_sv(2'b01, n + 10);
        push_sv(2'b10, n + 20);
        wait_cyc(n + 28);
        check("g_cap0_enable", latch_enable, 1);
        check("g_cap0_sel", sel, 0);
        #2 aclear_n = 1'b0;
        #1 check("g_async_reset", {conv_start, sel, latch_enable, latch_aclear,
                                   sample_valid, busy, timeout_err}, 0);
        wait_cyc(n + 30);
        push_sv(2'b01, n + 40);
        #2 aclear_n = 1'b1;
        wait_cyc(n + 33);
        run = 1'b0;
        wait_cyc(n + 41);
        check("g_busy_idle", busy, 0);

        k = 0;
        while ((sv_q.size() != 0 || clr_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_sv", sv_q.size(), 0);
        check("drain_clr", clr_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ui_axis_scheduler.md
# ui_axis_scheduler

Sequencer for the dual-axis measurement path. One conversion engine is shared between axis 0 and axis 1. This block alternates the engine between enabled axes round-robin and drives the select, enable and clear inputs of the downstream two-channel latch. It also sequences per-axis clears so that the latch's asynchronous clear never fires while the select line is moving.

## Interface
- SETTLE_CYCLES, 4: cycles the axis select is held stable before a conversion starts (0 allowed: the settle phase is skipped)
- TIMEOUT_CYCLES, 1024: CONV_DONE watchdog limit (used only with the macro)
- CNT_W, 16: width of the settle and timeout counters; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES)
- CLOCK  in  1  system clock, rising edge
- ACLEAR_N  in  1  asynchronous active-low reset
- RUN  in  1  scheduling enable, level-sensitive
- AXIS_EN  in  2  per-axis enable mask
- CLR_REQ  in  2  per-axis clear request pulse, captured into sticky pending bits
- CONV_DONE  in  1  engine result valid; data is held until the next CONV_START
- CONV_START  out  1  one-cycle conversion start pulse
- LATCH_AXIS_SEL  out  1  axis select to the latch and the analog front-end mux
- LATCH_ENABLE  out  1  latch enable
- LATCH_ACLEAR  out  1  latch clear, one-cycle pulse
- SAMPLE_VALID  out  2  one-cycle pulse: that axis's latch output has just updated
- BUSY  out  1  high in any state other than IDLE
- TIMEOUT_ERR  out  1  sticky watchdog flag (tied to 0 without the macro)

## Operation
- Reset: state IDLE, all outputs 0, pending clears 0, last-served axis = 1 (so axis 0 is served first).
- States: IDLE, SETTLE, CONVERT, CAP0, CAP1, REPORT, CLR_SET, CLR_PULSE, CLR_HOLD.
- Decision point is IDLE or REPORT:
  - Any pending clear → CLR_SET. If both axes are pending, lower index first.
  - Else if RUN=1 and AXIS_EN≠0 → SETTLE on the next enabled axis after the last served one. With only one axis enabled, that axis repeats.
  - Else → IDLE.
- SETTLE: LATCH_AXIS_SEL is driven to the target axis. Lasts SETTLE_CYCLES cycles, then → CONVERT.
- CONVERT: CONV_START=1 in the first cycle only. CONV_DONE is accepted from the following cycle; on acceptance → CAP0.
- CAP0: LATCH_ENABLE=1, which loads the first latch stage. Then CAP1: LATCH_ENABLE=1, which moves the data to the latch output. Then REPORT.
- REPORT: SAMPLE_VALID[axis]=1 for one cycle; last-served axis is updated. Then the decision point rules apply.
- Clear sequence:
  - CLR_SET: LATCH_AXIS_SEL set to the target axis.
  - CLR_PULSE: LATCH_ACLEAR=1.
  - CLR_HOLD: select unchanged; the pending bit is cleared. Then the decision point rules apply.
- CLR_REQ arriving during a conversion is held pending; a conversion is never aborted by a clear. A CLR_REQ arriving in the same cycle its pending bit is cleared re-sets that bit.
- RUN falling, or AXIS_EN changing, mid-conversion: the current conversion completes through REPORT, then the new values apply.
- CONV_DONE outside CONVERT, or in the CONV_START cycle, is ignored.
- LATCH_AXIS_SEL changes only on entry to SETTLE or CLR_SET. It is stable for every ENABLE cycle and every ACLEAR cycle.

## Timing
- All outputs are registered.
- Conversion latency: SETTLE entry to SAMPLE_VALID = SETTLE_CYCLES + 1 + D + 3 cycles, where D ≥ 1 is the cycle count from CONV_START to CONV_DONE.
- Clear sequence: 3 cycles. LATCH_ACLEAR is in cycle 2.
- Asynchronous reset mid-operation returns to IDLE immediately. Pending clears are dropped; the engine result is discarded.

## Configuration
- UI_AXIS_SCHED_TIMEOUT_EN defined:
  - A counter runs in CONVERT.
  - If CONV_DONE has not arrived after TIMEOUT_CYCLES cycles, TIMEOUT_ERR is set (sticky until reset). The state goes to REPORT with SAMPLE_VALID suppressed and the latch untouched.
- Not defined: CONVERT waits indefinitely; TIMEOUT_ERR is constant 0; no timeout counter is built.

## Structure
- Shared package ui_pkg holds:
  - the state enum ui_sched_state_t
  - the axis count constant UI_NUM_AXES = 2
  - the axis index typedef ui_axis_t
- One sub-module, ui_rr_pick: combinational round-robin next-axis selection from AXIS_EN and the last-served axis. All sequencing stays in the top module.

## Test plan
- SETTLE_CYCLES=4, AXIS_EN=11, RUN=1, engine D=3 → SAMPLE_VALID alternates 01, 10, 01. Each pulse is 11 cycles after its SETTLE entry; ENABLE is high for exactly 2 cycles with a stable select.
- AXIS_EN=10 → only axis 1 is served. SAMPLE_VALID=10 repeats; LATCH_AXIS_SEL stays 1.
- CLR_REQ=01 pulsed during CONVERT of axis 1 → conversion completes, then CLR_SET/CLR_PULSE/CLR_HOLD with select=0. ACLEAR is high 1 cycle; select is unchanged in the cycles before and after.
- CLR_REQ=11 in IDLE with RUN=0 → axis 0 cleared, then axis 1 cleared, back-to-back; then IDLE with BUSY=0.
- Macro on, TIMEOUT_CYCLES=16, CONV_DONE never asserted → TIMEOUT_ERR rises 16 cycles after CONV_START; no SAMPLE_VALID; the next axis is scheduled.
- ACLEAR_N asserted during CAP0 → all outputs 0 at once. After release, axis 0 is served first.
